// File: rtl/multi_pipe_mem.sv
// Elastic, stallable N-lane delay pipeline of H register stages.
// All lanes share one valid/ready handshake, so they stay aligned.
module multi_pipe_mem #(
    parameter int H  = 3,
    parameter int W  = 32,
    parameter int N  = 2,
    parameter int CW = $clog2(H + 1)
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [N*W-1:0]  in_data,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic            flush,
    output logic [N*W-1:0]  out_data,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [CW-1:0]   occupancy
);

    logic [N*W-1:0] data_p [H];
    logic [H-1:0]   vld_p;
    logic [H-1:0]   vld_next;
    logic [H-1:0]   load;

    function automatic logic [CW-1:0] popcount(input logic [H-1:0] v);
        logic [CW-1:0] cnt;
        cnt = '0;
        for (int i = 0; i < H; i++) begin
            cnt = cnt + CW'(v[i]);
        end
        return cnt;
    endfunction

    // A stage can load when the sink drains or any stage at or after it is empty.
    for (genvar g = 0; g < H; g++) begin : g_load
        assign load[g] = out_ready | ~(&vld_p[H-1:g]);
    end

    assign in_ready  = load[0] & ~flush;
    assign out_data  = data_p[H-1];
    assign out_valid = vld_p[H-1];

    always_comb begin
        vld_next = vld_p;
        if (flush) begin
            vld_next = '0;
        end else begin
            if (load[0]) begin
                vld_next[0] = in_valid;
            end
            for (int i = 1; i < H; i++) begin
                if (load[i]) begin
                    vld_next[i] = vld_p[i-1];
                end
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            vld_p     <= '0;
            occupancy <= '0;
        end else begin
            vld_p     <= vld_next;
            occupancy <= popcount(vld_next);
        end
    end

    // Data only moves behind a valid word, so empty slots never overwrite content.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < H; i++) begin
                data_p[i] <= '0;
            end
        end else if (!flush) begin
            if (load[0] && in_valid) begin
                data_p[0] <= in_data;
            end
            for (int i = 1; i < H; i++) begin
                if (load[i] && vld_p[i-1]) begin
                    data_p[i] <= data_p[i-1];
                end
            end
        end
    end

endmodule

// File: tb/tb_multi_pipe_mem.sv
// Directed and scoreboard checks for multi_pipe_mem at three parameter sets.
module tb_multi_pipe_mem;

    logic clk;
    logic reset;
    int   checks;
    int   failures;

    // Main instance H=3, N=2, W=32
    logic [63:0] a_in_data, a_out_data;
    logic        a_in_valid, a_in_ready, a_flush, a_out_valid, a_out_ready;
    logic [1:0]  a_occ;
    // Small instance H=1, N=1, W=8
    logic [7:0]  b_in_data, b_out_data;
    logic        b_in_valid, b_in_ready, b_flush, b_out_valid, b_out_ready;
    logic [0:0]  b_occ;
    // Wide instance H=8, N=4, W=16
    logic [63:0] c_in_data, c_out_data;
    logic        c_in_valid, c_in_ready, c_flush, c_out_valid, c_out_ready;
    logic [3:0]  c_occ;

    multi_pipe_mem #(.H(3), .W(32), .N(2)) u_a (
        .clk(clk), .reset(reset), .in_data(a_in_data), .in_valid(a_in_valid),
        .in_ready(a_in_ready), .flush(a_flush), .out_data(a_out_data),
        .out_valid(a_out_valid), .out_ready(a_out_ready), .occupancy(a_occ));

    multi_pipe_mem #(.H(1), .W(8), .N(1)) u_b (
        .clk(clk), .reset(reset), .in_data(b_in_data), .in_valid(b_in_valid),
        .in_ready(b_in_ready), .flush(b_flush), .out_data(b_out_data),
        .out_valid(b_out_valid), .out_ready(b_out_ready), .occupancy(b_occ));

    multi_pipe_mem #(.H(8), .W(16), .N(4)) u_c (
        .clk(clk), .reset(reset), .in_data(c_in_data), .in_valid(c_in_valid),
        .in_ready(c_in_ready), .flush(c_flush), .out_data(c_out_data),
        .out_valid(c_out_valid), .out_ready(c_out_ready), .occupancy(c_occ));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b0;
        tick();
        tick();
        checks++;
        if (a_out_valid !== 1'b0) begin failures++; $display("FAIL reset_out_valid got=%b want=0", a_out_valid); end
        checks++;
        if (a_out_data !== 64'h0) begin failures++; $display("FAIL reset_out_data got=%h want=0", a_out_data); end
        checks++;
        if (a_occ !== 2'd0) begin failures++; $display("FAIL reset_occupancy got=%0d want=0", a_occ); end
        checks++;
        if (a_in_ready !== 1'b1) begin failures++; $display("FAIL reset_in_ready got=%b want=1", a_in_ready); end
        checks++;
        if (b_out_valid !== 1'b0 || c_out_valid !== 1'b0 || c_occ !== 4'd0) begin
            failures++; $display("FAIL reset_other_inst got b_vld=%b c_vld=%b c_occ=%0d want 0/0/0", b_out_valid, c_out_valid, c_occ);
        end
        reset = 1'b1;
        tick();
    endtask

    task automatic test_async_reset();
        a_out_ready = 1'b0;
        a_in_valid  = 1'b1;
        a_in_data   = {32'hBB, 32'hAA};
        tick();
        a_in_data   = {32'hDD, 32'hCC};
        tick();
        a_in_valid  = 1'b0;
        tick();
        checks++;
        if (a_occ !== 2'd2 || a_out_valid !== 1'b1) begin
            failures++; $display("FAIL async_pre occ=%0d vld=%b want occ=2 vld=1", a_occ, a_out_valid);
        end
        #3;
        reset = 1'b0;
        #1;
        checks++;
        if (a_occ !== 2'd0 || a_out_valid !== 1'b0 || a_out_data !== 64'h0) begin
            failures++; $display("FAIL async_clear occ=%0d vld=%b data=%h want 0/0/0", a_occ, a_out_valid, a_out_data);
        end
        tick();
        reset = 1'b1;
        tick();
    endtask

    task automatic test_stream();
        logic [63:0] w [3];
        w[0] = {32'h22, 32'h11};
        w[1] = {32'h44, 32'h33};
        w[2] = {32'h66, 32'h55};
        a_out_ready = 1'b1;
        for (int cyc = 0; cyc < 6; cyc++) begin
            a_in_valid = (cyc < 3);
            a_in_data  = (cyc < 3) ? w[cyc] : 64'h0;
            #1;
            if (cyc < 3) begin
                checks++;
                if (a_in_ready !== 1'b1) begin failures++; $display("FAIL stream_in_ready cyc=%0d got=%b want=1", cyc, a_in_ready); end
            end
            tick();
            checks++;
            if (cyc >= 2 && cyc <= 4) begin
                if (a_out_valid !== 1'b1 || a_out_data !== w[cyc-2]) begin
                    failures++; $display("FAIL stream_out cyc=%0d got vld=%b data=%h want vld=1 data=%h", cyc, a_out_valid, a_out_data, w[cyc-2]);
                end
            end else begin
                if (a_out_valid !== 1'b0) begin failures++; $display("FAIL stream_gap cyc=%0d got vld=%b want=0", cyc, a_out_valid); end
            end
        end
        checks++;
        if (a_occ !== 2'd0) begin failures++; $display("FAIL stream_drained occ=%0d want=0", a_occ); end
    endtask

    task automatic test_backpressure();
        logic [63:0] w [4];
        w[0] = {32'hA1, 32'hA0};
        w[1] = {32'hB1, 32'hB0};
        w[2] = {32'hC1, 32'hC0};
        w[3] = {32'hD1, 32'hD0};
        a_out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            a_in_valid = 1'b1;
            a_in_data  = w[i];
            tick();
        end
        a_in_data = w[3];
        #1;
        checks++;
        if (a_occ !== 2'd3 || a_in_ready !== 1'b0) begin
            failures++; $display("FAIL bp_full occ=%0d in_ready=%b want occ=3 in_ready=0", a_occ, a_in_ready);
        end
        tick();
        checks++;
        if (a_occ !== 2'd3 || a_out_valid !== 1'b1 || a_out_data !== w[0]) begin
            failures++; $display("FAIL bp_stall occ=%0d vld=%b data=%h want 3/1/%h", a_occ, a_out_valid, a_out_data, w[0]);
        end
        a_out_ready = 1'b1;
        #1;
        checks++;
        if (a_in_ready !== 1'b1) begin failures++; $display("FAIL bp_full_ready got=%b want=1", a_in_ready); end
        tick();
        a_in_valid  = 1'b0;
        a_out_ready = 1'b0;
        checks++;
        if (a_occ !== 2'd3 || a_out_data !== w[1]) begin
            failures++; $display("FAIL bp_swap occ=%0d data=%h want occ=3 data=%h", a_occ, a_out_data, w[1]);
        end
        a_out_ready = 1'b1;
        for (int i = 2; i < 5; i++) begin
            tick();
            checks++;
            if (i < 4) begin
                if (a_out_valid !== 1'b1 || a_out_data !== w[i]) begin
                    failures++; $display("FAIL bp_drain i=%0d vld=%b data=%h want 1/%h", i, a_out_valid, a_out_data, w[i]);
                end
            end else if (a_out_valid !== 1'b0 || a_occ !== 2'd0) begin
                failures++; $display("FAIL bp_empty vld=%b occ=%0d want 0/0", a_out_valid, a_occ);
            end
        end
    endtask

    task automatic test_bubble();
        logic [63:0] e, f;
        e = {32'hE1, 32'hE0};
        f = {32'hF1, 32'hF0};
        a_out_ready = 1'b0;
        a_in_valid  = 1'b1;
        a_in_data   = e;
        tick();
        a_in_valid  = 1'b0;
        tick();
        tick();
        a_in_valid  = 1'b1;
        a_in_data   = f;
        tick();
        a_in_valid  = 1'b0;
        checks++;
        if (a_occ !== 2'd2) begin failures++; $display("FAIL bubble_occ got=%0d want=2", a_occ); end
        tick();
        checks++;
        if (a_occ !== 2'd2 || a_out_data !== e) begin
            failures++; $display("FAIL bubble_hold occ=%0d data=%h want 2/%h", a_occ, a_out_data, e);
        end
        a_out_ready = 1'b1;
        tick();
        checks++;
        if (a_out_valid !== 1'b1 || a_out_data !== f) begin
            failures++; $display("FAIL bubble_collapse vld=%b data=%h want 1/%h", a_out_valid, a_out_data, f);
        end
        tick();
        checks++;
        if (a_out_valid !== 1'b0 || a_occ !== 2'd0) begin
            failures++; $display("FAIL bubble_empty vld=%b occ=%0d want 0/0", a_out_valid, a_occ);
        end
    endtask

    task automatic test_flush();
        logic [63:0] w [3];
        w[0] = {32'h71, 32'h70};
        w[1] = {32'h81, 32'h80};
        w[2] = {32'h91, 32'h90};
        a_out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            a_in_valid = 1'b1;
            a_in_data  = w[i];
            tick();
        end
        a_flush     = 1'b1;
        a_in_valid  = 1'b1;
        a_in_data   = {32'hFF, 32'hEE};
        a_out_ready = 1'b1;
        #1;
        checks++;
        if (a_in_ready !== 1'b0 || a_out_valid !== 1'b1) begin
            failures++; $display("FAIL flush_cycle in_ready=%b vld=%b want 0/1", a_in_ready, a_out_valid);
        end
        tick();
        a_flush    = 1'b0;
        a_in_valid = 1'b0;
        checks++;
        if (a_occ !== 2'd0 || a_out_valid !== 1'b0) begin
            failures++; $display("FAIL flush_clear occ=%0d vld=%b want 0/0", a_occ, a_out_valid);
        end
        for (int i = 0; i < 4; i++) begin
            tick();
            checks++;
            if (a_out_valid !== 1'b0) begin failures++; $display("FAIL flush_leak i=%0d vld=%b data=%h want vld=0", i, a_out_valid, a_out_data); end
        end
    endtask

    task automatic test_sweep_small();
        logic [7:0] q[$];
        logic [7:0] seq, prev_data;
        logic       prev_stall;
        seq = 8'h01;
        prev_stall = 1'b0;
        prev_data  = '0;
        for (int cyc = 0; cyc < 400; cyc++) begin
            b_in_valid  = ($urandom_range(0, 3) != 0);
            b_in_data   = seq;
            b_out_ready = ($urandom_range(0, 2) != 0);
            #1;
            checks++;
            if (b_in_ready !== ((q.size() < 1) || b_out_ready)) begin
                failures++; $display("FAIL small_in_ready cyc=%0d got=%b q=%0d", cyc, b_in_ready, q.size());
            end
            if (b_out_valid && b_out_ready) begin
                checks++;
                if (q.size() == 0 || b_out_data !== q[0]) begin
                    failures++; $display("FAIL small_order cyc=%0d got=%h want=%h", cyc, b_out_data, (q.size() == 0) ? 8'hXX : q[0]);
                end
                if (q.size() != 0) void'(q.pop_front());
            end
            if (b_in_valid && b_in_ready) begin
                q.push_back(seq);
                seq = seq + 8'd1;
            end
            prev_stall = b_out_valid && !b_out_ready;
            prev_data  = b_out_data;
            tick();
            checks++;
            if ($isunknown(b_occ) || int'(b_occ) != q.size() || int'(b_occ) > 1) begin
                failures++; $display("FAIL small_occ cyc=%0d got=%0d want=%0d", cyc, b_occ, q.size());
            end
            if (prev_stall) begin
                checks++;
                if (b_out_valid !== 1'b1 || b_out_data !== prev_data) begin
                    failures++; $display("FAIL small_stable cyc=%0d got=%h want=%h", cyc, b_out_data, prev_data);
                end
            end
        end
        b_in_valid  = 1'b0;
        b_out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            #1;
            if (b_out_valid && q.size() != 0) begin
                checks++;
                if (b_out_data !== q[0]) begin failures++; $display("FAIL small_drain got=%h want=%h", b_out_data, q[0]); end
                void'(q.pop_front());
            end
            tick();
        end
        checks++;
        if (q.size() != 0 || b_out_valid !== 1'b0) begin
            failures++; $display("FAIL small_loss left=%0d vld=%b want 0/0", q.size(), b_out_valid);
        end
    endtask

    task automatic test_sweep_wide();
        logic [63:0] q[$];
        logic [63:0] word, prev_data;
        logic [15:0] seq;
        logic        prev_stall;
        seq = 16'h0100;
        prev_stall = 1'b0;
        prev_data  = '0;
        for (int cyc = 0; cyc < 600; cyc++) begin
            word        = {seq ^ 16'hC000, seq ^ 16'h8000, seq ^ 16'h4000, seq};
            c_in_valid  = ($urandom_range(0, 3) != 0);
            c_in_data   = word;
            c_out_ready = (cyc % 97 < 30) ? 1'b0 : ($urandom_range(0, 2) != 0);
            #1;
            checks++;
            if (c_in_ready !== ((q.size() < 8) || c_out_ready)) begin
                failures++; $display("FAIL wide_in_ready cyc=%0d got=%b q=%0d", cyc, c_in_ready, q.size());
            end
            if (c_out_valid && c_out_ready) begin
                checks++;
                if (q.size() == 0 || c_out_data !== q[0]) begin
                    failures++; $display("FAIL wide_order cyc=%0d got=%h want=%h", cyc, c_out_data, (q.size() == 0) ? 64'hX : q[0]);
                end
                if (q.size() != 0) void'(q.pop_front());
            end
            if (c_in_valid && c_in_ready) begin
                q.push_back(word);
                seq = seq + 16'd1;
            end
            prev_stall = c_out_valid && !c_out_ready;
            prev_data  = c_out_data;
            tick();
            checks++;
            if ($isunknown(c_occ) || int'(c_occ) != q.size() || int'(c_occ) > 8) begin
                failures++; $display("FAIL wide_occ cyc=%0d got=%0d want=%0d", cyc, c_occ, q.size());
            end
            if (prev_stall) begin
                checks++;
                if (c_out_valid !== 1'b1 || c_out_data !== prev_data) begin
                    failures++; $display("FAIL wide_stable cyc=%0d got=%h want=%h", cyc, c_out_data, prev_data);
                end
            end
        end
        c_in_valid  = 1'b0;
        c_out_ready = 1'b1;
        for (int i = 0; i < 12; i++) begin
            #1;
            if (c_out_valid && q.size() != 0) begin
                checks++;
                if (c_out_data !== q[0]) begin failures++; $display("FAIL wide_drain got=%h want=%h", c_out_data, q[0]); end
                void'(q.pop_front());
            end
            tick();
        end
        checks++;
        if (q.size() != 0 || c_out_valid !== 1'b0) begin
            failures++; $display("FAIL wide_loss left=%0d vld=%b want 0/0", q.size(), c_out_valid);
        end
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        reset = 1'b0;
        a_in_data = '0; a_in_valid = 1'b0; a_flush = 1'b0; a_out_ready = 1'b0;
        b_in_data = '0; b_in_valid = 1'b0; b_flush = 1'b0; b_out_ready = 1'b0;
        c_in_data = '0; c_in_valid = 1'b0; c_flush = 1'b0; c_out_ready = 1'b0;
        test_reset();
        test_async_reset();
        test_stream();
        test_backpressure();
        test_bubble();
        test_flush();
        test_sweep_small();
        test_sweep_wide();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/multi_pipe_mem.md
Name: multi_pipe_mem

Overview:
- Elastic, stallable delay pipeline that carries N parallel W-bit channels through H register stages under one shared valid/ready handshake.
- Generalises the fixed two-channel, free-running delay pair:
  - configurable channel count;
  - per-stage valid tracking with bubble collapsing;
  - downstream backpressure;
  - synchronous flush;
  - occupancy reporting.
- Sits between datapath stages that must stay lane-aligned while the consumer can stall.

Parameters:
- H, 3, number of register stages (latency in cycles); legal range 1..64.
- W, 32, width of each channel in bits.
- N, 2, number of parallel channels; legal range 1..16.
- CW, $clog2(H+1), width of the occupancy output (derived; do not override).

Ports:
- clk, input, 1, rising-edge clock.
- reset, input, 1, asynchronous active-low reset: asserted when 0, released synchronously to clk.
- in_data, input, N*W, channel k occupies bits [k*W +: W].
- in_valid, input, 1, upstream word present.
- in_ready, output, 1, block can accept a word this cycle.
- flush, input, 1, synchronous discard of all contents.
- out_data, output, N*W, data held in the last stage, lane layout same as in_data.
- out_valid, output, 1, last stage holds a valid word.
- out_ready, input, 1, downstream accepts a word this cycle.
- occupancy, output, CW, number of valid stages (0..H).

Behaviour:
- Reset (reset=0, asynchronous):
  - all stage valid bits go to 0;
  - all stage data registers go to 0;
  - out_valid=0, out_data=0, occupancy=0.
  - in_ready is combinational and reads 1 during reset.
  - Reset asserted mid-operation drops all in-flight words immediately, without waiting for a clock edge.
- Stages are numbered 0..H-1. Stage H-1 drives out_data and out_valid. Let v[i] be the stage valid bit.
- Load enables (combinational):
  - load[H-1] = ~v[H-1] | out_ready
  - load[i] = ~v[i] | load[i+1]
  - in_ready = load[0] & ~flush
- On each clk edge with flush=0:
  - If load[0]: v[0] <= in_valid; data[0] <= in_data when in_valid=1, otherwise data[0] holds.
  - If load[i] for i>0: v[i] <= v[i-1]; data[i] <= data[i-1] when v[i-1]=1, otherwise holds.
  - If load[i]=0: stage i holds both data and valid.
- Bubbles collapse: an empty stage always accepts from upstream, even when downstream is stalled.
- Latency: a word accepted in cycle t (in_valid & in_ready) appears on out_data with out_valid=1 in cycle t+H when out_ready stays high. Back-to-back throughput is 1 word per cycle.
- Transfer out happens when out_valid & out_ready.
- out_data is undefined-free: it retains the last value when out_valid=0 and never changes while out_valid=1 and out_ready=0.
- Full condition:
  - all H stages valid and out_ready=0 gives in_ready=0.
  - all H stages valid and out_ready=1 gives in_ready=1. Simultaneous accept and emit is legal, and occupancy stays H.
- Empty condition: out_valid=0, occupancy=0. in_valid=1 then gives occupancy 1 on the next cycle.
- Flush:
  - On an edge with flush=1, all v[i] <= 0; data registers hold.
  - in_ready=0 during the flush cycle, so the input word is not accepted.
  - A word presented at the output in the flush cycle may still be taken by downstream (out_valid is still 1 in that cycle); the flush clears it afterwards regardless.
  - Flush has priority over load.
- occupancy is registered: it equals the popcount of v[] after each edge and updates in the same cycle as the valid bits.
- All channels share one valid and one ready. Lanes can never skew relative to each other.

Test Plan:
- Reset with H=3, N=2, W=32:
  - hold reset=0 -> out_valid=0, out_data=0, occupancy=0, in_ready=1.
  - drop reset mid-stream with 2 words in flight -> all cleared asynchronously, before the next clk edge.
- Streaming, out_ready=1: inject words 0x11/0x22, 0x33/0x44, 0x55/0x66 on consecutive cycles -> each appears on lanes 0/1 exactly 3 cycles later, in order, with no gaps.
- Backpressure:
  - fill with 3 words, out_ready=0 -> occupancy=3, in_ready=0, out_data stable.
  - raise out_ready for one cycle with in_valid=1 -> one word out, one word in, occupancy stays 3.
- Bubble collapse: inject a word, idle 2 cycles, inject a second word, hold out_ready=0 -> the second word advances into stage 1 behind the first, and occupancy reaches 2.
- Flush: with 3 valid words, assert flush for 1 cycle with in_valid=1 -> in_ready=0 in that cycle, occupancy=0 and out_valid=0 on the next cycle, and the input word is never emitted.
- Parameter sweep: run H=1, N=1, W=8 and H=8, N=4, W=16 under random in_valid/out_ready against a FIFO scoreboard model -> no loss, no duplication, order preserved, occupancy always in 0..H.
